machine_timer: RTL



---
 rtl/machine_timer.sv | 129 ++++++++++++
 1 files changed

// File: rtl/machine_timer.sv
// machine_timer: memory-mapped 64-bit mtime/mtimecmp timer with a prescaler.
// Single-cycle req/gnt/rvalid data port; level interrupt on mtime >= mtimecmp.
module machine_timer #(
  parameter int BASE_W     = 5,
  parameter int PRESCALE_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [3:0]        be,
  input  logic [BASE_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              gnt,
  output logic              rvalid,
  output logic [31:0]       rdata,
  output logic              timer_irq
);

  localparam int IDX_W = BASE_W - 2;

  logic [63:0]           mtime_q, mtime_d, mtime_inc;
  logic [63:0]           mtimecmp_q, mtimecmp_d;
  logic                  en_q, en_d;
  logic [PRESCALE_W-1:0] presc_q, presc_d;
  logic [PRESCALE_W-1:0] pcnt_q, pcnt_d;
  logic                  rvalid_q;
  logic [31:0]           rdata_q, rd_val;
  logic                  irq_q;

  logic [IDX_W-1:0] idx;
  logic [31:0]      mask;
  logic             wr_en, rd_en, tick;
  logic             sel_lo, sel_hi, sel_clo, sel_chi, sel_ctrl;
  logic             unused_addr;

  assign gnt         = req;
  assign wr_en       = req & we;
  assign rd_en       = req & ~we;
  assign idx         = addr[BASE_W-1:2];
  assign unused_addr = ^addr[1:0];
  assign mask        = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};

  assign sel_lo   = (idx == IDX_W'(0));
  assign sel_hi   = (idx == IDX_W'(1));
  assign sel_clo  = (idx == IDX_W'(2));
  assign sel_chi  = (idx == IDX_W'(3));
  assign sel_ctrl = (idx == IDX_W'(4));

  // Prescaler terminal count: mtime advances when pcnt has reached PRESC.
  assign tick      = en_q & (pcnt_q == presc_q);
  assign mtime_inc = mtime_q + {63'd0, tick};

  // Next-state for mtime: written bytes override, others take the incremented
  // value (which already carries from LO into HI).
  always_comb begin
    mtime_d = mtime_inc;
    if (wr_en && sel_lo)
      mtime_d[31:0] = (mtime_inc[31:0] & ~mask) | (wdata & mask);
    if (wr_en && sel_hi)
      mtime_d[63:32] = (mtime_inc[63:32] & ~mask) | (wdata & mask);
  end

  // Next-state for mtimecmp with per-byte write merge.
  always_comb begin
    mtimecmp_d = mtimecmp_q;
    if (wr_en && sel_clo)
      mtimecmp_d[31:0] = (mtimecmp_q[31:0] & ~mask) | (wdata & mask);
    if (wr_en && sel_chi)
      mtimecmp_d[63:32] = (mtimecmp_q[63:32] & ~mask) | (wdata & mask);
  end

  // Next-state for CTRL fields and the prescale counter; any CTRL write restarts pcnt.
  always_comb begin
    en_d    = en_q;
    presc_d = presc_q;
    if (en_q)
      pcnt_d = tick ? '0 : pcnt_q + 1'b1;
    else
      pcnt_d = pcnt_q;
    if (wr_en && sel_ctrl) begin
      en_d = be[0] ? wdata[0] : en_q;
      for (int i = 0; i < PRESCALE_W; i++)
        presc_d[i] = mask[8+i] ? wdata[8+i] : presc_q[i];
      pcnt_d = '0;
    end
  end

  // Read mux over current register values (before any same-cycle increment).
  always_comb begin
    rd_val = '0;
    if (sel_lo)  rd_val = mtime_q[31:0];
    if (sel_hi)  rd_val = mtime_q[63:32];
    if (sel_clo) rd_val = mtimecmp_q[31:0];
    if (sel_chi) rd_val = mtimecmp_q[63:32];
    if (sel_ctrl) begin
      rd_val[0]               = en_q;
      rd_val[8 +: PRESCALE_W] = presc_q;
    end
  end

  // Register update, response pipeline and registered interrupt level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mtime_q    <= '0;
      mtimecmp_q <= '1;
      en_q       <= 1'b0;
      presc_q    <= '0;
      pcnt_q     <= '0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      irq_q      <= 1'b0;
    end else begin
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      en_q       <= en_d;
      presc_q    <= presc_d;
      pcnt_q     <= pcnt_d;
      rvalid_q   <= req;
      rdata_q    <= rd_en ? rd_val : 32'd0;
      irq_q      <= (mtime_q >= mtimecmp_q);
    end
  end

  assign rvalid    = rvalid_q;
  assign rdata     = rdata_q;
  assign timer_irq = irq_q;

endmodule
